// File: rtl/xbar_nxm.sv
// xbar_nxm: N-master x M-slave req/ack crossbar with per-slave locked arbitration
module xbar_nxm #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        master_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] master_addr,
  input  logic [NUM_MASTERS-1:0]        master_cmd,
  input  logic [NUM_MASTERS*DATA_W-1:0] master_wdata,
  output logic [NUM_MASTERS-1:0]        master_ack,
  output logic [NUM_MASTERS*DATA_W-1:0] master_rdata,
  output logic [NUM_SLAVES-1:0]         slave_req,
  output logic [NUM_SLAVES*ADDR_W-1:0]  slave_addr,
  output logic [NUM_SLAVES-1:0]         slave_cmd,
  output logic [NUM_SLAVES*DATA_W-1:0]  slave_wdata,
  input  logic [NUM_SLAVES-1:0]         slave_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0]  slave_rdata
);
  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int MW    = $clog2(NUM_MASTERS);
  logic [SEL_W-1:0]      tgt [NUM_MASTERS];
  logic [NUM_SLAVES-1:0] lock_vld, rd_vld, gvld;
  logic [MW-1:0]         lock_own [NUM_SLAVES];
  logic [MW-1:0]         rr_ptr [NUM_SLAVES];
  logic [MW-1:0]         rd_own [NUM_SLAVES];
  logic [MW-1:0]         gnt [NUM_SLAVES];
  logic [MW-1:0]         idx;
  // target slave of each master from the address MSBs
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) tgt[i] = master_addr[i*ADDR_W+ADDR_W-1 -: SEL_W];
  end
  // per-slave grant: held owner while locked, otherwise first requester from rr_ptr (or from 0)
  always_comb begin
    idx = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      gvld[j] = lock_vld[j];
      gnt[j] = lock_own[j];
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = MW'(ARB_MODE == 0 ? (int'(rr_ptr[j]) + k) % NUM_MASTERS : k);
        if (!gvld[j] && master_req[idx] && tgt[idx] == SEL_W'(j)) begin
          gvld[j] = 1'b1;
          gnt[j] = idx;
        end
      end
    end
  end
  // forward the granted master to each slave, steer acks and one-cycle-late read data back
  always_comb begin
    slave_req = '0;
    slave_addr = '0;
    slave_cmd = '0;
    slave_wdata = '0;
    master_ack = '0;
    master_rdata = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (rst && gvld[j]) begin
        slave_req[j] = master_req[gnt[j]];
        slave_addr[j*ADDR_W +: ADDR_W] = master_addr[gnt[j]*ADDR_W +: ADDR_W];
        slave_cmd[j] = master_cmd[gnt[j]];
        slave_wdata[j*DATA_W +: DATA_W] = master_wdata[gnt[j]*DATA_W +: DATA_W];
        master_ack[gnt[j]] = master_ack[gnt[j]] | slave_ack[j];
      end
      if (rst && rd_vld[j]) master_rdata[rd_own[j]*DATA_W +: DATA_W] = slave_rdata[j*DATA_W +: DATA_W];
    end
  end
  // lock a grant until ack, advance the round-robin pointer past the acked owner, mark read returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_vld <= '0;
      rd_vld <= '0;
      for (int j = 0; j < NUM_SLAVES; j++) begin
        lock_own[j] <= '0;
        rr_ptr[j] <= '0;
        rd_own[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_SLAVES; j++) begin
        lock_vld[j] <= gvld[j] && !slave_ack[j];
        rd_vld[j] <= gvld[j] && slave_ack[j] && !master_cmd[gnt[j]];
        if (gvld[j]) begin
          lock_own[j] <= gnt[j];
          rd_own[j] <= gnt[j];
        end
        if (ARB_MODE == 0 && gvld[j] && slave_ack[j])
          rr_ptr[j] <= gnt[j] == MW'(NUM_MASTERS - 1) ? '0 : gnt[j] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xbar_nxm.sv
// tb_xbar_nxm: directed checks of the 2x2 crossbar in round-robin and fixed-priority modes
module tb_xbar_nxm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] mreq, mcmd, sack, mack, sreq, scmd, f_mack, f_sreq, f_scmd;
  logic [63:0] maddr, mwdata, srdata, mrdata, saddr, swdata, f_mrdata, f_saddr, f_swdata;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  xbar_nxm dut (
    .clk(clk), .rst(rst), .master_req(mreq), .master_addr(maddr), .master_cmd(mcmd),
    .master_wdata(mwdata), .master_ack(mack), .master_rdata(mrdata), .slave_req(sreq),
    .slave_addr(saddr), .slave_cmd(scmd), .slave_wdata(swdata), .slave_ack(sack),
    .slave_rdata(srdata)
  );
  xbar_nxm #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .master_req(mreq), .master_addr(maddr), .master_cmd(mcmd),
    .master_wdata(mwdata), .master_ack(f_mack), .master_rdata(f_mrdata), .slave_req(f_sreq),
    .slave_addr(f_saddr), .slave_cmd(f_scmd), .slave_wdata(f_swdata), .slave_ack(sack),
    .slave_rdata(srdata)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    mreq = '0;
    mcmd = '0;
    maddr = '0;
    mwdata = '0;
    sack = '0;
    srdata = '0;
  endtask
  task automatic test_reset;
    idle();
    mreq = 2'b01;
    mcmd = 2'b01;
    maddr[31:0] = 32'h0000_0100;
    mwdata[31:0] = 32'h11;
    #1;
    checks++; if (sreq !== 2'b00) begin errors++; $display("FAIL rst_hold_sreq got %b exp %b", sreq, 2'b00); end
    checks++; if (mack !== 2'b00) begin errors++; $display("FAIL rst_hold_mack got %b exp %b", mack, 2'b00); end
    step();
    rst = 1'b1;
    sack = 2'b01;
    #1;
    checks++; if (mack !== 2'b01) begin errors++; $display("FAIL rst_first_ack got %b exp %b", mack, 2'b01); end
    step();
    mreq = 2'b11;
    maddr = {32'h0000_0300, 32'h0000_0200};
    mwdata = {32'h33, 32'h22};
    mcmd = 2'b11;
    sack = 2'b00;
    #1;
    checks++; if (saddr[31:0] !== 32'h300) begin errors++; $display("FAIL rst_rr_m1 got %h exp %h", saddr[31:0], 32'h300); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (sreq !== 2'b00) begin errors++; $display("FAIL rst_mid_sreq got %b exp %b", sreq, 2'b00); end
    checks++; if (saddr !== 64'h0) begin errors++; $display("FAIL rst_mid_saddr got %h exp %h", saddr, 64'h0); end
    checks++; if (swdata !== 64'h0) begin errors++; $display("FAIL rst_mid_swdata got %h exp %h", swdata, 64'h0); end
    checks++; if (scmd !== 2'b00) begin errors++; $display("FAIL rst_mid_scmd got %b exp %b", scmd, 2'b00); end
    checks++; if (mack !== 2'b00) begin errors++; $display("FAIL rst_mid_mack got %b exp %b", mack, 2'b00); end
    checks++; if (mrdata !== 64'h0) begin errors++; $display("FAIL rst_mid_mrdata got %h exp %h", mrdata, 64'h0); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (saddr[31:0] !== 32'h200) begin errors++; $display("FAIL rst_restart_m0 got %h exp %h", saddr[31:0], 32'h200); end
    checks++; if (sreq !== 2'b01) begin errors++; $display("FAIL rst_restart_sreq got %b exp %b", sreq, 2'b01); end
    sack = 2'b01;
    #1;
    checks++; if (mack !== 2'b01) begin errors++; $display("FAIL rst_restart_ack got %b exp %b", mack, 2'b01); end
    step();
    mreq = 2'b10;
    #1;
    checks++; if (mack !== 2'b10) begin errors++; $display("FAIL rst_drain_ack got %b exp %b", mack, 2'b10); end
    step();
    idle();
    step();
  endtask
  task automatic test_rr_contention;
    int n0 = 0;
    int n1 = 0;
    int acks = 0;
    logic [1:0] exp_ack;
    logic [31:0] exp_addr;
    idle();
    mcmd = 2'b11;
    sack = 2'b01;
    for (int c = 0; c < 8; c++) begin
      mreq = {n1 < 4, n0 < 4};
      maddr = {32'h0000_1100 + 32'(n1 * 4), 32'h0000_1000 + 32'(n0 * 4)};
      mwdata = {32'hB000_0000 + 32'(n1), 32'hA000_0000 + 32'(n0)};
      #1;
      exp_ack = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (c % 2 == 0) ? 32'h0000_1000 + 32'(n0 * 4) : 32'h0000_1100 + 32'(n1 * 4);
      checks++; if (mack !== exp_ack) begin errors++; $display("FAIL rr_ack c%0d got %b exp %b", c, mack, exp_ack); end
      checks++; if (saddr[31:0] !== exp_addr) begin errors++; $display("FAIL rr_addr c%0d got %h exp %h", c, saddr[31:0], exp_addr); end
      acks += int'(mack[0]) + int'(mack[1]);
      if (c % 2 == 0) n0++; else n1++;
      step();
    end
    checks++; if (acks !== 8) begin errors++; $display("FAIL rr_total got %0d exp %0d", acks, 8); end
    idle();
    step();
  endtask
  task automatic test_lock;
    idle();
    mreq = 2'b10;
    mcmd = 2'b11;
    maddr = {32'h0000_0040, 32'h0000_0050};
    mwdata = {32'hB1, 32'hA0};
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) mreq = 2'b11;
      sack = (c == 3) ? 2'b01 : 2'b00;
      #1;
      checks++; if (saddr[31:0] !== 32'h40) begin errors++; $display("FAIL lock_addr c%0d got %h exp %h", c, saddr[31:0], 32'h40); end
      checks++; if (f_saddr[31:0] !== 32'h40) begin errors++; $display("FAIL lock_fp_addr c%0d got %h exp %h", c, f_saddr[31:0], 32'h40); end
      checks++; if (mack !== ((c == 3) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL lock_ack c%0d got %b exp %b", c, mack, (c == 3) ? 2'b10 : 2'b00); end
      step();
    end
    mreq = 2'b01;
    sack = 2'b01;
    #1;
    checks++; if (saddr[31:0] !== 32'h50) begin errors++; $display("FAIL lock_next_addr got %h exp %h", saddr[31:0], 32'h50); end
    checks++; if (mack !== 2'b01) begin errors++; $display("FAIL lock_next_ack got %b exp %b", mack, 2'b01); end
    step();
    idle();
    step();
  endtask
  task automatic test_single_write;
    idle();
    mreq = 2'b01;
    mcmd = 2'b01;
    maddr[31:0] = 32'h0000_0010;
    mwdata[31:0] = 32'hDEAD_BEEF;
    sack = 2'b01;
    #1;
    checks++; if (sreq !== 2'b01) begin errors++; $display("FAIL wr_sreq got %b exp %b", sreq, 2'b01); end
    checks++; if (saddr !== 64'h0000_0000_0000_0010) begin errors++; $display("FAIL wr_saddr got %h exp %h", saddr, 64'h10); end
    checks++; if (swdata !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL wr_swdata got %h exp %h", swdata, 64'hDEAD_BEEF); end
    checks++; if (scmd !== 2'b01) begin errors++; $display("FAIL wr_scmd got %b exp %b", scmd, 2'b01); end
    checks++; if (mack !== 2'b01) begin errors++; $display("FAIL wr_mack got %b exp %b", mack, 2'b01); end
    step();
    idle();
    #1;
    checks++; if (mrdata !== 64'h0) begin errors++; $display("FAIL wr_no_rdata got %h exp %h", mrdata, 64'h0); end
    step();
  endtask
  task automatic test_single_read;
    int acks = 0;
    idle();
    mreq = 2'b10;
    maddr[63:32] = 32'h8000_0004;
    for (int c = 0; c < 3; c++) begin
      sack = (c == 2) ? 2'b10 : 2'b00;
      #1;
      checks++; if (sreq !== 2'b10) begin errors++; $display("FAIL rd_sreq c%0d got %b exp %b", c, sreq, 2'b10); end
      checks++; if (saddr[63:32] !== 32'h8000_0004) begin errors++; $display("FAIL rd_saddr c%0d got %h exp %h", c, saddr[63:32], 32'h8000_0004); end
      acks += int'(mack[1]);
      step();
    end
    mreq = 2'b00;
    sack = 2'b00;
    srdata[63:32] = 32'h1234_5678;
    #1;
    acks += int'(mack[1]);
    checks++; if (mrdata[63:32] !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h exp %h", mrdata[63:32], 32'h1234_5678); end
    checks++; if (mrdata[31:0] !== 32'h0) begin errors++; $display("FAIL rd_other got %h exp %h", mrdata[31:0], 32'h0); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL rd_ack_pulses got %0d exp %0d", acks, 1); end
    step();
    checks++; if (mrdata !== 64'h0) begin errors++; $display("FAIL rd_data_once got %h exp %h", mrdata, 64'h0); end
    idle();
    step();
  endtask
  task automatic test_parallel_fixed;
    idle();
    mreq = 2'b11;
    maddr = {32'h0000_0030, 32'h8000_0020};
    sack = 2'b11;
    #1;
    checks++; if (mack !== 2'b11) begin errors++; $display("FAIL par_ack got %b exp %b", mack, 2'b11); end
    checks++; if (saddr !== {32'h8000_0020, 32'h0000_0030}) begin errors++; $display("FAIL par_saddr got %h exp %h", saddr, {32'h8000_0020, 32'h0000_0030}); end
    step();
    idle();
    srdata = {32'hAAAA_1111, 32'h5555_2222};
    #1;
    checks++; if (mrdata !== {32'h5555_2222, 32'hAAAA_1111}) begin errors++; $display("FAIL par_rdata got %h exp %h", mrdata, {32'h5555_2222, 32'hAAAA_1111}); end
    step();
    idle();
    mreq = 2'b11;
    mcmd = 2'b11;
    maddr = {32'h0000_0064, 32'h0000_0060};
    sack = 2'b01;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (f_mack !== 2'b01) begin errors++; $display("FAIL fp_ack c%0d got %b exp %b", c, f_mack, 2'b01); end
      checks++; if (f_saddr[31:0] !== 32'h60) begin errors++; $display("FAIL fp_addr c%0d got %h exp %h", c, f_saddr[31:0], 32'h60); end
      step();
    end
    idle();
    step();
  endtask
  initial begin
    idle();
    test_reset();
    test_rr_contention();
    test_lock();
    test_single_write();
    test_single_read();
    test_parallel_fixed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
